// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared types and round-robin pick helper for packet_arbiter
package pkt_arb_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int RR_MAX_N   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set request at or above ptr, wrapping modulo n (n <= RR_MAX_N).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [2:0]          ptr,
                                       input int unsigned         n);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      pos = ({29'd0, ptr} + k) % n;
      if (k < n && !res.found && req[pos[2:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// rtl/rr_arbiter_core.sv - combinational round-robin winner selection
module rr_arbiter_core
  import pkt_arb_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned CHANNEL_WIDTH = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0]      req_i,
  input  logic [CHANNEL_WIDTH-1:0] ptr_i,
  output logic [CHANNEL_WIDTH-1:0] winner_o,
  output logic                     found_o
);

  logic [RR_MAX_N-1:0] req_ext;
  logic [2:0]          ptr_ext;
  rr_pick_t            pick;

  always_comb begin
    req_ext                  = '0;
    req_ext[N_INPUTS-1:0]    = req_i;
    ptr_ext                  = '0;
    ptr_ext[CHANNEL_WIDTH-1:0] = ptr_i;
    pick                     = rr_pick(req_ext, ptr_ext, N_INPUTS);
    winner_o                 = pick.idx[CHANNEL_WIDTH-1:0];
    found_o                  = pick.found;
  end

endmodule

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - packet-level round-robin arbiter onto one Avalon-ST sink
module packet_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned AST_DWIDTH    = 64,
  parameter int unsigned BITS_PER_SYMB = 8,
  parameter int unsigned EMPTY_WIDTH   = $clog2(AST_DWIDTH / BITS_PER_SYMB),
  parameter int unsigned CHANNEL_WIDTH = $clog2(N_INPUTS)
) (
  input  logic                              clk_i,
  input  logic                              srst_i,
  input  logic [N_INPUTS*AST_DWIDTH-1:0]    snk_data_i,
  input  logic [N_INPUTS-1:0]               snk_valid_i,
  input  logic [N_INPUTS-1:0]               snk_sop_i,
  input  logic [N_INPUTS-1:0]               snk_eop_i,
  input  logic [N_INPUTS*EMPTY_WIDTH-1:0]   snk_empty_i,
  output logic [N_INPUTS-1:0]               snk_ready_o,
  output logic [AST_DWIDTH-1:0]             src_data_o,
  output logic                              src_valid_o,
  output logic                              src_sop_o,
  output logic                              src_eop_o,
  output logic [EMPTY_WIDTH-1:0]            src_empty_o,
  output logic [CHANNEL_WIDTH-1:0]          src_channel_o,
  input  logic                              src_ready_i,
  output logic [DROP_CNT_W-1:0]             drop_cnt_o
);

  state_e                    state_q, state_d;
  logic [CHANNEL_WIDTH-1:0]  grant_q, grant_d;
  logic [CHANNEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [N_INPUTS-1:0]       req;
  logic [N_INPUTS-1:0]       stray;
  logic [3:0]                stray_n;
  logic [DROP_CNT_W:0]       drop_sum;
  logic [CHANNEL_WIDTH-1:0]  winner;
  logic                      found;

  assign req   = snk_valid_i & snk_sop_i;
  assign stray = snk_valid_i & ~snk_sop_i;

  rr_arbiter_core #(
    .N_INPUTS      (N_INPUTS),
    .CHANNEL_WIDTH (CHANNEL_WIDTH)
  ) u_rr_core (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    snk_ready_o   = '0;
    src_data_o    = '0;
    src_valid_o   = 1'b0;
    src_sop_o     = 1'b0;
    src_eop_o     = 1'b0;
    src_empty_o   = '0;
    src_channel_o = '0;

    stray_n = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      stray_n = stray_n + {3'b000, stray[i]};
    end
    drop_sum = {1'b0, drop_cnt_q} + {{(DROP_CNT_W-3){1'b0}}, stray_n};

    case (state_q)
      IDLE: begin
        // Strays are swallowed here so a source can never stall arbitration
        // with a headless packet tail.
        snk_ready_o = stray;
        drop_cnt_d  = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        if (found) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        src_data_o           = snk_data_i[grant_q*AST_DWIDTH +: AST_DWIDTH];
        src_valid_o          = snk_valid_i[grant_q];
        src_sop_o            = snk_sop_i[grant_q];
        src_eop_o            = snk_eop_i[grant_q];
        src_empty_o          = snk_empty_i[grant_q*EMPTY_WIDTH +: EMPTY_WIDTH];
        src_channel_o        = grant_q;
        snk_ready_o[grant_q] = src_ready_i;
        if (snk_valid_i[grant_q] && snk_eop_i[grant_q] && src_ready_i) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == CHANNEL_WIDTH'(N_INPUTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (srst_i) begin
      snk_ready_o = '0;
      src_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - self-checking bench for packet_arbiter with a queue-based model
module tb_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            srst;
  logic [N*DW-1:0] snk_data;
  logic [N-1:0]    snk_valid, snk_sop, snk_eop, snk_ready;
  logic [N*EW-1:0] snk_empty;
  logic [DW-1:0]   src_data;
  logic            src_valid, src_sop, src_eop, src_ready;
  logic [EW-1:0]   src_empty;
  logic [CW-1:0]   src_channel;
  logic [15:0]     drop_cnt;

  always #5 clk = ~clk;

  packet_arbiter #(
    .N_INPUTS(N), .AST_DWIDTH(DW), .BITS_PER_SYMB(8), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW)
  ) dut (
    .clk_i(clk), .srst_i(srst),
    .snk_data_i(snk_data), .snk_valid_i(snk_valid), .snk_sop_i(snk_sop),
    .snk_eop_i(snk_eop), .snk_empty_i(snk_empty), .snk_ready_o(snk_ready),
    .src_data_o(src_data), .src_valid_o(src_valid), .src_sop_o(src_sop),
    .src_eop_o(src_eop), .src_empty_o(src_empty), .src_channel_o(src_channel),
    .src_ready_i(src_ready), .drop_cnt_o(drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct {
    beat_t b;
    int    ch;
    int    cyc;
  } obs_t;

  beat_t     srcq[N][$];
  beat_t     mq[N][$];
  obs_t      obs_q[$];
  beat_t     exp_b[$];
  int        exp_ch[$];
  int        rdy_pat[$];
  int        total = 0, bad = 0, cyc = 0, proto_err = 0, mptr = 0;
  bit        rdy_rand = 0, eop_prev = 0;
  logic      snap_valid;
  logic [N-1:0] snap_ready;

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        snk_valid[i]          = 1'b1;
        snk_data[i*DW +: DW]  = srcq[i][0].data;
        snk_sop[i]            = srcq[i][0].sop;
        snk_eop[i]            = srcq[i][0].eop;
        snk_empty[i*EW +: EW] = srcq[i][0].empty;
      end else begin
        snk_valid[i]          = 1'b0;
        snk_data[i*DW +: DW]  = '0;
        snk_sop[i]            = 1'b0;
        snk_eop[i]            = 1'b0;
        snk_empty[i*EW +: EW] = '0;
      end
    end
  endtask

  // One clock: observe at negedge, advance sources after the rising edge.
  task automatic step();
    logic [N-1:0] acc, onehot;
    beat_t        ob;
    obs_t         o;
    @(negedge clk);
    snap_valid = src_valid;
    snap_ready = snk_ready;
    if (eop_prev && src_valid) proto_err++;
    eop_prev = 0;
    if (src_valid) begin
      onehot = '0;
      onehot[src_channel] = 1'b1;
      if (snk_ready[src_channel] !== src_ready) proto_err++;
      if ((snk_ready & ~onehot) !== '0) proto_err++;
      if (src_ready) begin
        ob.data = src_data; ob.sop = src_sop; ob.eop = src_eop; ob.empty = src_empty;
        o.b = ob; o.ch = int'(src_channel); o.cyc = cyc;
        obs_q.push_back(o);
        eop_prev = src_eop;
      end
    end
    acc = snk_valid & snk_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
    if (rdy_pat.size() > 0) src_ready = rdy_pat.pop_front() != 0;
    else src_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic run(input int maxc, output bit tmo);
    int n = 0;
    while (pending() && n < maxc) begin
      step();
      n++;
    end
    tmo = pending();
    repeat (2) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    srst = 1'b1;
    src_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    cyc = 0; mptr = 0; proto_err = 0; eop_prev = 0;
    obs_q.delete();
    rdy_pat.delete();
  endtask

  task automatic add_pkt(input int s, input int len, input logic [EW-1:0] last_empty, input bit seq);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = seq ? DW'(k + 1) : {$urandom, $urandom};
      b.sop   = (k == 0);
      b.eop   = (k == len - 1);
      b.empty = (k == len - 1) ? last_empty : '0;
      srcq[s].push_back(b);
    end
  endtask

  task automatic add_strays(input int s, input int cnt);
    beat_t b;
    for (int k = 0; k < cnt; k++) begin
      b.data = {$urandom, $urandom}; b.sop = 1'b0; b.eop = 1'b0; b.empty = '0;
      srcq[s].push_back(b);
    end
  endtask

  // Reference: whole packets handed out round-robin from the pointer among
  // sources that have one waiting; pointer moves past each winner.
  task automatic build_expected();
    int    idx;
    bit    done;
    beat_t b;
    for (int i = 0; i < N; i++) mq[i] = srcq[i];
    exp_b.delete();
    exp_ch.delete();
    forever begin
      idx = -1;
      for (int k = 0; k < N; k++)
        if (idx < 0 && mq[(mptr + k) % N].size() > 0) idx = (mptr + k) % N;
      if (idx < 0) break;
      done = 0;
      while (!done && mq[idx].size() > 0) begin
        b = mq[idx].pop_front();
        exp_b.push_back(b);
        exp_ch.push_back(idx);
        done = b.eop;
      end
      mptr = (idx + 1) % N;
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    src_ready = 1'b1;
    add_pkt(0, 2, 3'd0, 1);
    add_strays(1, 4);
    drive();
    repeat (2) begin
      @(negedge clk);
      total++;
      if (src_valid !== 1'b0 || snk_ready !== '0) begin
        bad++;
        $display("FAIL reset_outputs valid=%b ready=%b required valid=0 ready=0", src_valid, snk_ready);
      end
    end
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    total++;
    if (drop_cnt !== 16'd0 || src_data !== '0 || src_channel !== '0 || src_sop !== 1'b0 ||
        src_eop !== 1'b0 || src_empty !== '0 || src_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle drop=%0d data=%h ch=%0d sop=%b eop=%b empty=%0d valid=%b required all 0",
               drop_cnt, src_data, src_channel, src_sop, src_eop, src_empty, src_valid);
    end
  endtask

  task automatic test_single();
    bit tmo;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      add_pkt(0, 3, (r == 0) ? 3'd0 : 3'd5, 1);
      build_expected();
      drive();
      run(50, tmo);
      total++;
      if (tmo || obs_q.size() != 3) begin
        bad++;
        $display("FAIL single_count run=%0d beats=%0d required 3 timeout=%0d", r, obs_q.size(), tmo);
      end
      for (int k = 0; k < obs_q.size() && k < 3; k++) begin
        total++;
        if (obs_q[k].b !== exp_b[k] || obs_q[k].ch != 0 || obs_q[k].cyc != k + 1 ||
            obs_q[k].b.data !== DW'(k + 1)) begin
          bad++;
          $display("FAIL single_beat run=%0d k=%0d got data=%h sop=%b eop=%b empty=%0d ch=%0d cyc=%0d required data=%h sop=%b eop=%b empty=%0d ch=0 cyc=%0d",
                   r, k, obs_q[k].b.data, obs_q[k].b.sop, obs_q[k].b.eop, obs_q[k].b.empty,
                   obs_q[k].ch, obs_q[k].cyc, exp_b[k].data, exp_b[k].sop, exp_b[k].eop,
                   exp_b[k].empty, k + 1);
        end
      end
      total++;
      if (drop_cnt !== 16'd0 || proto_err != 0) begin
        bad++;
        $display("FAIL single_misc drop=%0d proto=%0d required 0 0", drop_cnt, proto_err);
      end
    end
  endtask

  task automatic test_contention();
    bit tmo;
    int exp_cyc[4] = '{1, 2, 4, 5};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      obs_q.delete();
      add_pkt(0, 2, 3'd1, 0);
      add_pkt(1, 2, 3'd2, 0);
      build_expected();
      cyc = 0;
      drive();
      run(50, tmo);
      total++;
      if (tmo || obs_q.size() != 4) begin
        bad++;
        $display("FAIL contention_count round=%0d beats=%0d required 4", r, obs_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < 4; k++) begin
        total++;
        if (obs_q[k].b !== exp_b[k] || obs_q[k].ch != k / 2 || obs_q[k].cyc != exp_cyc[k]) begin
          bad++;
          $display("FAIL contention_beat round=%0d k=%0d got ch=%0d cyc=%0d data=%h required ch=%0d cyc=%0d data=%h",
                   r, k, obs_q[k].ch, obs_q[k].cyc, obs_q[k].b.data, k / 2, exp_cyc[k], exp_b[k].data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit tmo;
    int exp_cyc[4] = '{1, 4, 5, 6};
    do_reset();
    add_pkt(0, 4, 3'd6, 0);
    add_pkt(2, 1, 3'd4, 0);
    build_expected();
    rdy_pat = '{1, 0, 0, 1};
    drive();
    run(60, tmo);
    total++;
    if (tmo || obs_q.size() != exp_b.size()) begin
      bad++;
      $display("FAIL bp_count beats=%0d required %0d", obs_q.size(), exp_b.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_b.size(); k++) begin
      total++;
      if (obs_q[k].b !== exp_b[k] || obs_q[k].ch != exp_ch[k] || (k < 4 && obs_q[k].cyc != exp_cyc[k])) begin
        bad++;
        $display("FAIL bp_beat k=%0d got ch=%0d cyc=%0d data=%h required ch=%0d data=%h",
                 k, obs_q[k].ch, obs_q[k].cyc, obs_q[k].b.data, exp_ch[k], exp_b[k].data);
      end
    end
    total++;
    if (proto_err != 0) begin
      bad++;
      $display("FAIL bp_ready_mirror errors=%0d required 0", proto_err);
    end
  endtask

  task automatic test_strays();
    bit tmo;
    int sent;
    do_reset();
    add_strays(1, 3);
    drive();
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (snap_ready[1] !== 1'b1 || snap_valid !== 1'b0) begin
        bad++;
        $display("FAIL stray_ready k=%0d ready1=%b valid=%b required 1 0", k, snap_ready[1], snap_valid);
      end
    end
    total++;
    if (drop_cnt !== 16'd3 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL stray_count drop=%0d beats=%0d required 3 0", drop_cnt, obs_q.size());
    end
    do_reset();
    sent = 65534;
    for (int i = 0; i < N; i++) add_strays(i, sent / N + ((i < sent % N) ? 1 : 0));
    drive();
    run(20000, tmo);
    total++;
    if (tmo || drop_cnt !== 16'(sent)) begin
      bad++;
      $display("FAIL stray_preload drop=%0d required %0d", drop_cnt, sent);
    end
    add_strays(1, 3);
    drive();
    for (int k = 0; k < 3; k++) begin
      step();
      sent++;
      total++;
      if (drop_cnt !== 16'((sent > 65535) ? 65535 : sent)) begin
        bad++;
        $display("FAIL stray_saturate k=%0d drop=%0d required %0d", k, drop_cnt, (sent > 65535) ? 65535 : sent);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    int n = 0;
    do_reset();
    add_pkt(0, 5, 3'd0, 1);
    drive();
    while (obs_q.size() < 2 && n < 20) begin
      step();
      n++;
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    total++;
    if (snap_valid !== 1'b0 || snap_ready !== '0) begin
      bad++;
      $display("FAIL midrst_during valid=%b ready=%b required 0 0", snap_valid, snap_ready);
    end
    srcq[0].delete();
    add_pkt(1, 2, 3'd7, 0);
    obs_q.delete();
    mptr = 0;
    build_expected();
    drive();
    step();
    total++;
    if (snap_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after valid=%b required 0", snap_valid);
    end
    run(50, tmo);
    total++;
    if (tmo || obs_q.size() != 2 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midrst_count beats=%0d drop=%0d required 2 0", obs_q.size(), drop_cnt);
    end
    for (int k = 0; k < obs_q.size() && k < 2; k++) begin
      total++;
      if (obs_q[k].b !== exp_b[k] || obs_q[k].ch != 1) begin
        bad++;
        $display("FAIL midrst_beat k=%0d got ch=%0d data=%h required ch=1 data=%h",
                 k, obs_q[k].ch, obs_q[k].b.data, exp_b[k].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    do_reset();
    for (int i = 0; i < N; i++) for (int p = 0; p < 3; p++) add_pkt(i, 1, 3'(p), 0);
    build_expected();
    drive();
    run(100, tmo);
    total++;
    if (tmo || obs_q.size() != 3 * N) begin
      bad++;
      $display("FAIL b2b_count beats=%0d required %0d", obs_q.size(), 3 * N);
    end
    for (int k = 0; k < obs_q.size() && k < 3 * N; k++) begin
      total++;
      if (obs_q[k].ch != k % N || obs_q[k].cyc != 1 + 2 * k || obs_q[k].b !== exp_b[k]) begin
        bad++;
        $display("FAIL b2b_beat k=%0d got ch=%0d cyc=%0d required ch=%0d cyc=%0d",
                 k, obs_q[k].ch, obs_q[k].cyc, k % N, 1 + 2 * k);
      end
    end
  endtask

  task automatic test_random();
    bit tmo;
    do_reset();
    rdy_rand = 1;
    for (int it = 0; it < 6; it++) begin
      obs_q.delete();
      proto_err = 0;
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 5), 3'($urandom_range(0, 7)), 0);
      end
      build_expected();
      drive();
      run(2000, tmo);
      total++;
      if (tmo || obs_q.size() != exp_b.size() || proto_err != 0) begin
        bad++;
        $display("FAIL rand_count it=%0d beats=%0d required %0d proto=%0d timeout=%0d",
                 it, obs_q.size(), exp_b.size(), proto_err, tmo);
      end
      for (int k = 0; k < obs_q.size() && k < exp_b.size(); k++) begin
        total++;
        if (obs_q[k].b !== exp_b[k] || obs_q[k].ch != exp_ch[k]) begin
          bad++;
          $display("FAIL rand_beat it=%0d k=%0d got ch=%0d data=%h sop=%b eop=%b empty=%0d required ch=%0d data=%h sop=%b eop=%b empty=%0d",
                   it, k, obs_q[k].ch, obs_q[k].b.data, obs_q[k].b.sop, obs_q[k].b.eop, obs_q[k].b.empty,
                   exp_ch[k], exp_b[k].data, exp_b[k].sop, exp_b[k].eop, exp_b[k].empty);
        end
      end
    end
    rdy_rand = 0;
  endtask

  initial begin
    srst      = 1'b1;
    src_ready = 1'b1;
    snk_data  = '0;
    snk_valid = '0;
    snk_sop   = '0;
    snk_eop   = '0;
    snk_empty = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_strays();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
